// File: rtl/fb_wr_sched.sv
// Frame-buffer DPRAM write scheduler: merges host pixel writes and a range-fill
// engine onto one paced write stream, alternating grants under contention.
module fb_wr_sched #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 8,
    parameter int FB_LAST = 172799,
    parameter int MIN_GAP = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              H_REQ,
    input  logic [ADDR_W-1:0] H_ADDR,
    input  logic [DATA_W-1:0] H_DATA,
    output logic              H_ACK,
    output logic              H_ERR,
    input  logic              F_START,
    input  logic [ADDR_W-1:0] F_BASE,
    input  logic [ADDR_W-1:0] F_LAST,
    input  logic [DATA_W-1:0] F_DATA,
    output logic              F_BUSY,
    output logic              F_DONE,
    output logic              WR,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] DIN
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [ADDR_W-1:0] FB_LAST_A = ADDR_W'(FB_LAST);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP - 1);

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fill_state_t;

    fill_state_t       state_r;
    fill_state_t       next_state_s;
    logic [GAP_W-1:0]  gap_r;
    logic              prio_host_r;
    logic [ADDR_W-1:0] fill_ptr_r;
    logic [ADDR_W-1:0] fill_last_r;
    logic [DATA_W-1:0] fill_data_r;

    logic              slot_s;
    logic              host_elig_s;
    logic              fill_elig_s;
    logic              grant_host_s;
    logic              grant_fill_s;
    logic              host_bad_s;
    logic              fill_final_s;
    logic [ADDR_W-1:0] f_last_clamp_s;
    logic              f_load_s;
    logic              f_reject_s;

    function automatic logic [ADDR_W-1:0] clamp_last(input logic [ADDR_W-1:0] last);
        clamp_last = (last > FB_LAST_A) ? FB_LAST_A : last;
    endfunction

    // Issue-slot arbitration; H_ACK masks the host for the cycle after a grant.
    always_comb begin
        slot_s         = (gap_r == {GAP_W{1'b0}});
        host_elig_s    = H_REQ & ~H_ACK;
        fill_elig_s    = (state_r == F_RUN);
        host_bad_s     = (H_ADDR > FB_LAST_A);
        fill_final_s   = (fill_ptr_r == fill_last_r);
        f_last_clamp_s = clamp_last(F_LAST);
        grant_host_s   = 1'b0;
        grant_fill_s   = 1'b0;
        if (slot_s) begin
            if (host_elig_s && (!fill_elig_s || prio_host_r)) begin
                grant_host_s = 1'b1;
            end else begin
                grant_fill_s = fill_elig_s;
            end
        end else begin
            grant_host_s = 1'b0;
        end
    end

    // Fill FSM next state; commands arriving while running are ignored.
    always_comb begin
        next_state_s = state_r;
        f_load_s     = 1'b0;
        f_reject_s   = 1'b0;
        case (state_r)
            F_IDLE: begin
                if (F_START) begin
                    f_load_s = 1'b1;
                    if (F_BASE > f_last_clamp_s) begin
                        f_reject_s   = 1'b1;
                        next_state_s = F_IDLE;
                    end else begin
                        next_state_s = F_RUN;
                    end
                end else begin
                    next_state_s = F_IDLE;
                end
            end
            F_RUN: begin
                if (grant_fill_s && fill_final_s) begin
                    next_state_s = F_IDLE;
                end else begin
                    next_state_s = F_RUN;
                end
            end
            default: next_state_s = F_IDLE;
        endcase
    end

    // FSM state, pacing counter and round-robin pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= F_IDLE;
            gap_r       <= {GAP_W{1'b0}};
            prio_host_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            if (grant_host_s || grant_fill_s) begin
                gap_r <= GAP_LOAD;
            end else if (!slot_s) begin
                gap_r <= gap_r - GAP_W'(1);
            end else begin
                gap_r <= gap_r;
            end
            if (grant_host_s) begin
                prio_host_r <= 1'b0;
            end else if (grant_fill_s) begin
                prio_host_r <= 1'b1;
            end else begin
                prio_host_r <= prio_host_r;
            end
        end
    end

    // Fill command registers and address pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_ptr_r  <= {ADDR_W{1'b0}};
            fill_last_r <= {ADDR_W{1'b0}};
            fill_data_r <= {DATA_W{1'b0}};
        end else if (f_load_s) begin
            fill_ptr_r  <= F_BASE;
            fill_last_r <= f_last_clamp_s;
            fill_data_r <= F_DATA;
        end else if (grant_fill_s) begin
            fill_ptr_r  <= fill_ptr_r + ADDR_W'(1);
        end else begin
            fill_ptr_r  <= fill_ptr_r;
        end
    end

    // Registered DPRAM write port and handshake outputs; an out-of-range host
    // grant consumes a slot but leaves WADDR/DIN untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WR     <= 1'b0;
            WADDR  <= {ADDR_W{1'b0}};
            DIN    <= {DATA_W{1'b0}};
            H_ACK  <= 1'b0;
            H_ERR  <= 1'b0;
            F_BUSY <= 1'b0;
            F_DONE <= 1'b0;
        end else begin
            WR     <= grant_fill_s | (grant_host_s & ~host_bad_s);
            H_ACK  <= grant_host_s;
            H_ERR  <= grant_host_s & host_bad_s;
            F_BUSY <= (next_state_s == F_RUN);
            F_DONE <= f_reject_s | (grant_fill_s & fill_final_s);
            if (grant_fill_s) begin
                WADDR <= fill_ptr_r;
                DIN   <= fill_data_r;
            end else if (grant_host_s && !host_bad_s) begin
                WADDR <= H_ADDR;
                DIN   <= H_DATA;
            end else begin
                WADDR <= WADDR;
                DIN   <= DIN;
            end
        end
    end

endmodule

// File: tb/tb_fb_wr_sched.sv
// Scoreboard bench for fb_wr_sched: each task queues the writes it expects and
// a negedge monitor pops and compares them as WR pulses appear.
module tb_fb_wr_sched;

    localparam int MIN_GAP = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        H_REQ = 1'b0;
    logic [19:0] H_ADDR = 20'h0;
    logic [7:0]  H_DATA = 8'h0;
    logic        H_ACK, H_ERR;
    logic        F_START = 1'b0;
    logic [19:0] F_BASE = 20'h0;
    logic [19:0] F_LAST = 20'h0;
    logic [7:0]  F_DATA = 8'h0;
    logic        F_BUSY, F_DONE, WR;
    logic [19:0] WADDR;
    logic [7:0]  DIN;

    fb_wr_sched #(.ADDR_W(20), .DATA_W(8), .FB_LAST(172799), .MIN_GAP(MIN_GAP)) dut (
        .CLK(CLK), .RST(RST),
        .H_REQ(H_REQ), .H_ADDR(H_ADDR), .H_DATA(H_DATA), .H_ACK(H_ACK), .H_ERR(H_ERR),
        .F_START(F_START), .F_BASE(F_BASE), .F_LAST(F_LAST), .F_DATA(F_DATA),
        .F_BUSY(F_BUSY), .F_DONE(F_DONE),
        .WR(WR), .WADDR(WADDR), .DIN(DIN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
        logic        host;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_wr_cyc = 0;
    bit   have_last = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard monitor: every WR pulse must match the head of the queue.
    always @(negedge CLK) begin
        if (!RST && WR === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr: got WADDR=%h DIN=%h, expected no write", WADDR, DIN);
            end else begin
                mon_e = exp_q.pop_front();
                if ({WADDR, DIN, H_ACK, F_DONE} !== {mon_e.addr, mon_e.data, mon_e.host, mon_e.done}) begin
                    errors++;
                    $display("FAIL wr_item: got addr=%h data=%h ack=%b done=%b, expected addr=%h data=%h ack=%b done=%b",
                             WADDR, DIN, H_ACK, F_DONE, mon_e.addr, mon_e.data, mon_e.host, mon_e.done);
                end
                if (!mon_e.host) begin
                    checks++;
                    if (F_BUSY !== !mon_e.done) begin
                        errors++;
                        $display("FAIL wr_busy: got F_BUSY=%b, expected %b", F_BUSY, !mon_e.done);
                    end
                end
            end
            if (have_last) begin
                checks++;
                if (cyc - last_wr_cyc < MIN_GAP) begin
                    errors++;
                    $display("FAIL wr_gap: got %0d cycles between writes, expected >= %0d", cyc - last_wr_cyc, MIN_GAP);
                end
            end
            last_wr_cyc = cyc;
            have_last   = 1'b1;
        end
    end

    task automatic push(input logic [19:0] a, input logic [7:0] d, input logic h, input logic dn);
        exp_t e;
        e.addr = a; e.data = d; e.host = h; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        RST = 1'b1; H_REQ = 1'b0; F_START = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        have_last = 1'b0;
    endtask

    task automatic f_cmd(input logic [19:0] base, input logic [19:0] last, input logic [7:0] data);
        @(negedge CLK);
        F_BASE = base; F_LAST = last; F_DATA = data; F_START = 1'b1;
        @(negedge CLK);
        F_START = 1'b0;
    endtask

    task automatic host_write(input logic [19:0] a, input logic [7:0] d, input logic exp_err, output int ack_cyc);
        bit got = 1'b0;
        H_ADDR = a; H_DATA = d; H_REQ = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (H_ACK === 1'b1) begin got = 1'b1; break; end
        end
        ack_cyc = cyc;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL host_ack_timeout: got no H_ACK for addr %h, expected H_ACK", a);
        end else if (H_ERR !== exp_err || (exp_err && WR !== 1'b0)) begin
            errors++;
            $display("FAIL host_err: got H_ERR=%b WR=%b, expected H_ERR=%b WR=%b", H_ERR, WR, exp_err, !exp_err);
        end
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (F_DONE === 1'b1) begin got = 1'b1; break; end
        end
        #1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done_timeout: got no F_DONE, expected F_DONE pulse", name);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d writes outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({WR, H_ACK, H_ERR, F_BUSY, F_DONE, WADDR, DIN} !== 33'h0) begin
            errors++;
            $display("FAIL reset_held: got outputs %h, expected 0", {WR, H_ACK, H_ERR, F_BUSY, F_DONE, WADDR, DIN});
        end
        do_reset();
        @(negedge CLK);
        checks++;
        if ({WR, H_ACK, H_ERR, F_BUSY, F_DONE, WADDR, DIN} !== 33'h0) begin
            errors++;
            $display("FAIL reset_idle: got outputs %h, expected 0", {WR, H_ACK, H_ERR, F_BUSY, F_DONE, WADDR, DIN});
        end
    endtask

    task automatic test_host();
        int c1, c2;
        do_reset();
        push(20'h00010, 8'hF0, 1'b1, 1'b0);
        push(20'h00011, 8'h30, 1'b1, 1'b0);
        host_write(20'h00010, 8'hF0, 1'b0, c1);
        host_write(20'h00011, 8'h30, 1'b0, c2);
        H_REQ = 1'b0;
        #1;
        checks++;
        if (c2 - c1 != MIN_GAP || exp_q.size() != 0) begin
            errors++;
            $display("FAIL host_spacing: got gap %0d pending %0d, expected gap %0d pending 0", c2 - c1, exp_q.size(), MIN_GAP);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int a = 4; a <= 7; a++) push(20'(a), 8'hA0, 1'b0, a == 7);
        f_cmd(20'd4, 20'd7, 8'hA0);
        checks++;
        if (F_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL fill_busy_start: got F_BUSY=%b, expected 1", F_BUSY);
        end
        wait_done("fill");
    endtask

    task automatic test_contention();
        int c;
        do_reset();
        push(20'd0, 8'h11, 1'b0, 1'b0);
        push(20'd100, 8'h64, 1'b1, 1'b0);
        push(20'd1, 8'h11, 1'b0, 1'b0);
        push(20'd101, 8'h65, 1'b1, 1'b0);
        push(20'd2, 8'h11, 1'b0, 1'b0);
        push(20'd102, 8'h66, 1'b1, 1'b0);
        push(20'd3, 8'h11, 1'b0, 1'b0);
        push(20'd4, 8'h11, 1'b0, 1'b0);
        push(20'd5, 8'h11, 1'b0, 1'b1);
        f_cmd(20'd0, 20'd5, 8'h11);
        fork
            wait_done("contention");
            begin
                @(negedge CLK);
                for (int k = 0; k < 3; k++) host_write(20'(100 + k), 8'(8'h64 + k), 1'b0, c);
                H_REQ = 1'b0;
            end
        join
    endtask

    task automatic test_host_err();
        int c1, c2;
        do_reset();
        push(20'h00020, 8'h55, 1'b1, 1'b0);
        host_write(20'd172800, 8'h77, 1'b1, c1);
        checks++;
        if (WADDR !== 20'h0 || DIN !== 8'h0) begin
            errors++;
            $display("FAIL err_hold: got WADDR=%h DIN=%h, expected 00000/00", WADDR, DIN);
        end
        host_write(20'h00020, 8'h55, 1'b0, c2);
        H_REQ = 1'b0;
        #1;
        checks++;
        if (c2 - c1 != MIN_GAP || exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_spacing: got gap %0d pending %0d, expected gap %0d pending 0", c2 - c1, exp_q.size(), MIN_GAP);
        end
    endtask

    task automatic test_degenerate();
        bit bad = 1'b0;
        do_reset();
        f_cmd(20'd10, 20'd5, 8'h22);
        checks++;
        if (F_DONE !== 1'b1 || F_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got F_DONE=%b F_BUSY=%b, expected 1/0", F_DONE, F_BUSY);
        end
        repeat (6) begin
            @(negedge CLK);
            if (F_BUSY !== 1'b0 || F_DONE !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL empty_quiet: got F_BUSY/F_DONE activity, expected none");
        end
        push(20'd172798, 8'h5A, 1'b0, 1'b0);
        push(20'd172799, 8'h5A, 1'b0, 1'b1);
        f_cmd(20'd172798, 20'hFFFFF, 8'h5A);
        wait_done("clamp");
    endtask

    task automatic test_reset_mid_fill();
        bit bad = 1'b0;
        do_reset();
        push(20'h00100, 8'hC0, 1'b0, 1'b0);
        push(20'h00101, 8'hC0, 1'b0, 1'b0);
        f_cmd(20'h00100, 20'h00107, 8'hC0);
        f_cmd(20'h00200, 20'h00201, 8'h33);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midfill_writes: got %0d writes outstanding, expected 0", exp_q.size());
        end
        RST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (WR !== 1'b0 || F_BUSY !== 1'b0 || F_DONE !== 1'b0) bad = 1'b1;
        end
        RST = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (F_BUSY !== 1'b0 || F_DONE !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midfill_abort: got WR/F_BUSY/F_DONE activity around reset, expected none");
        end
        push(20'h00300, 8'h90, 1'b0, 1'b0);
        push(20'h00301, 8'h90, 1'b0, 1'b1);
        f_cmd(20'h00300, 20'h00301, 8'h90);
        wait_done("refill");
    endtask

    initial begin
        test_reset();
        test_host();
        test_fill();
        test_contention();
        test_host_err();
        test_degenerate();
        test_reset_mid_fill();
        repeat (4) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
